// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared constants, types and output-register states for the
//                8x4 FIFO read-side controller.
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_pkg;

    // Data width, address width and the resulting memory depth.
    localparam int DW    = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 2 ** AW;

    typedef logic [DW-1:0] data_t;
    typedef logic [AW-1:0] addr_t;
    typedef logic [AW:0]   cnt_t;

    // Output register occupancy.
    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_VALID = 1'b1
    } out_state_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ptr
//  Description : AW-bit wrapping memory pointer. Advances by one on inc and
//                wraps from 2**AW-1 back to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_ptr #(
    parameter int AW = fifo_pkg::AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] r_ptr;

    // Pointer register; the power-of-two depth makes the wrap a natural
    // overflow of the AW-bit adder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign ptr = r_ptr;

endmodule : fifo_ptr
`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_ctrl
//  Description : Read-side controller for the 8x4 dual-port memory. Owns the
//                write/read pointers and the occupancy count, prefetches the
//                head word into a registered output and delivers it over a
//                valid/ready handshake. Reports empty/full/level to the writer.
//  Options     : FIFO_RD_CTRL_OVF_EN - adds a sticky overflow flag (ovf) that
//                records pushes dropped while full, cleared by ovf_clr.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_rd_ctrl #(
    parameter int DW = fifo_pkg::DW,
    parameter int AW = fifo_pkg::AW
) (
    input  logic          clk,
    input  logic          rst_n,
    // Writer side
    input  logic          wr_push,
    output logic [AW-1:0] wr_addr,
    // Memory read port
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_rd_data,
    // Consumer side
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    // Status
    output logic          empty,
    output logic          full,
`ifdef FIFO_RD_CTRL_OVF_EN
    input  logic          ovf_clr,
    output logic          ovf,
`endif
    output logic [AW:0]   level
);

    import fifo_pkg::*;

    localparam int unsigned c_DEPTH_I = 2 ** AW;
    localparam logic [AW:0] c_DEPTH   = c_DEPTH_I[AW:0];

    out_state_t    r_state;
    out_state_t    w_state_nxt;
    logic [AW:0]   r_count;
    logic [AW:0]   w_pend;
    logic [DW-1:0] r_data;
    logic [AW-1:0] w_wr_ptr;
    logic [AW-1:0] w_rd_ptr;
    logic          w_full;
    logic          w_valid;
    logic          w_push;
    logic          w_pop;
    logic          w_load;

    // ------------------------------------------------------------------
    // Handshake qualifiers. full is the pre-edge value, so a push offered
    // while full is dropped even if a pop frees a slot in the same cycle.
    // ------------------------------------------------------------------
    assign w_full  = (r_count == c_DEPTH);
    assign w_valid = (r_state == OUT_VALID);
    assign w_push  = wr_push && !w_full;
    assign w_pop   = w_valid && rd_ready;

    // Words that sit in memory but have not yet been moved into the output
    // register. The held output word is still counted in r_count because its
    // memory slot is only released when the consumer pops it.
    assign w_pend  = r_count - {{AW{1'b0}}, w_valid};

    // ------------------------------------------------------------------
    // Pointers
    // ------------------------------------------------------------------
    fifo_ptr #(
        .AW    (AW)
    ) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_push),
        .ptr   (w_wr_ptr)
    );

    fifo_ptr #(
        .AW    (AW)
    ) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_load),
        .ptr   (w_rd_ptr)
    );

    // Output register state; holds the current occupancy of rd_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= OUT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and load decision: refill the output register whenever it
    // is empty or being popped and memory still holds an unloaded word.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            OUT_EMPTY: begin
                if (w_pend != '0) begin
                    w_load      = 1'b1;
                    w_state_nxt = OUT_VALID;
                end
            end
            OUT_VALID: begin
                if (w_pop) begin
                    if (w_pend != '0) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = OUT_EMPTY;
                    end
                end
            end
            default: begin
                w_state_nxt = OUT_EMPTY;
            end
        endcase
    end

    // Output data register; keeps its last value when nothing is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (w_load) begin
            r_data <= mem_rd_data;
        end
    end

    // Occupancy count; a simultaneous push and pop cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FIFO_RD_CTRL_OVF_EN
    logic r_ovf;

    // Sticky overflow flag; a new dropped push wins over a clear request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (wr_push && w_full) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wr_addr     = w_wr_ptr;
    assign mem_rd_addr = w_rd_ptr;
    assign rd_valid    = w_valid;
    assign rd_data     = r_data;
    assign empty       = (r_count == '0);
    assign full        = w_full;
    assign level       = r_count;

endmodule : fifo_rd_ctrl
`default_nettype wire
